// File: rtl/stack_mem_responder.sv
// Responder side of the register-file PUSH/PULL stack: owns the stack store and $sp (r29 image).
// Optional overflow/underflow blocking with sticky Stack_Err is enabled by defining STACK_GUARD_EN.
module stack_mem_responder #(
   parameter int            DEPTH   = 16,
   parameter int            DW      = 32,
   parameter logic [DW-1:0] INIT_SP = DW'(32'h54)
) (
   input  logic          Clock,
   input  logic          Resetn,
   input  logic          Push_Req,
   input  logic          Pull_Req,
   input  logic [DW-1:0] Push_Data,
   output logic          Req_Ack,
   output logic [DW-1:0] Pull_Data,
   output logic          Pull_Valid,
   output logic [DW-1:0] SP_Out,
   output logic          Full,
   output logic          Empty,
   output logic          Stack_Err
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
   localparam logic [AW:0]   CNT_ONE = {{AW{1'b0}}, 1'b1};
   localparam logic [AW-1:0] IDX_ONE = {{(AW-1){1'b0}}, 1'b1};
   localparam logic [DW-1:0] SP_ONE  = {{(DW-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      ST_INIT = 2'd0,
      ST_IDLE = 2'd1,
      ST_READ = 2'd2,
      ST_ACK  = 2'd3
   } state_t;

   state_t          state_r, state_s;
   logic [DW-1:0]   sp_r, sp_s;
   logic [DW-1:0]   pull_data_r, pull_data_s;
   logic [AW:0]     count_r, count_s;
   logic            ack_r, ack_s;
   logic            valid_r, valid_s;
   logic            err_r, err_s;
   logic            swap_r, swap_s;
   logic            wr_en_s;
   logic [AW-1:0]   wr_idx_s;
   logic [DW-1:0]   wr_data_s;
   logic [AW-1:0]   push_idx_s, top_idx_s;
   logic            full_s, empty_s;
   logic            guard_push_s, guard_pull_s;
   logic [DW-1:0]   mem_r [DEPTH];

   // The count keeps one spare bit so Full is distinguishable; the store index wraps mod DEPTH.
   assign push_idx_s = count_r[AW-1:0];
   assign top_idx_s  = push_idx_s - IDX_ONE;
   assign full_s     = (count_r == DEPTH_C);
   assign empty_s    = (count_r == {(AW+1){1'b0}});

`ifdef STACK_GUARD_EN
   assign guard_push_s = full_s;
   assign guard_pull_s = empty_s;
`else
   assign guard_push_s = 1'b0;
   assign guard_pull_s = 1'b0;
`endif

   // Next-state and next-register values for the request FSM.
   always_comb begin
      state_s     = state_r;
      sp_s        = sp_r;
      count_s     = count_r;
      pull_data_s = pull_data_r;
      ack_s       = 1'b0;
      valid_s     = 1'b0;
      err_s       = err_r;
      swap_s      = swap_r;
      wr_en_s     = 1'b0;
      wr_idx_s    = push_idx_s;
      wr_data_s   = Push_Data;
      if (!Resetn) begin
         state_s     = ST_INIT;
         sp_s        = {DW{1'b0}};
         count_s     = {(AW+1){1'b0}};
         pull_data_s = {DW{1'b0}};
         err_s       = 1'b0;
         swap_s      = 1'b0;
      end else begin
         case (state_r)
            ST_INIT: begin
               sp_s    = INIT_SP;
               state_s = ST_IDLE;
            end
            ST_IDLE: begin
               if (Push_Req && Pull_Req) begin
                  swap_s  = 1'b1;
                  state_s = ST_READ;
               end else if (Push_Req) begin
                  if (guard_push_s) begin
                     err_s = 1'b1;
                  end else begin
                     wr_en_s = 1'b1;
                     sp_s    = sp_r + SP_ONE;
                     count_s = count_r + CNT_ONE;
                  end
                  ack_s   = 1'b1;
                  state_s = ST_ACK;
               end else if (Pull_Req) begin
                  swap_s  = 1'b0;
                  state_s = ST_READ;
               end else begin
                  state_s = ST_IDLE;
               end
            end
            ST_READ: begin
               ack_s   = 1'b1;
               valid_s = 1'b1;
               state_s = ST_ACK;
               if (guard_pull_s) begin
                  pull_data_s = {DW{1'b0}};
                  err_s       = 1'b1;
               end else begin
                  pull_data_s = mem_r[top_idx_s];
                  if (swap_r) begin
                     wr_en_s  = 1'b1;
                     wr_idx_s = top_idx_s;
                  end else begin
                     sp_s    = sp_r - SP_ONE;
                     count_s = count_r - CNT_ONE;
                  end
               end
            end
            ST_ACK: begin
               state_s = ST_IDLE;
            end
            default: begin
               state_s = ST_INIT;
            end
         endcase
      end
   end

   // State and output registers, updated on the falling edge like the rest of the pipeline.
   always_ff @(negedge Clock) begin
      state_r     <= state_s;
      sp_r        <= sp_s;
      count_r     <= count_s;
      pull_data_r <= pull_data_s;
      ack_r       <= ack_s;
      valid_r     <= valid_s;
      err_r       <= err_s;
      swap_r      <= swap_s;
   end

   // Stack store; deliberately not cleared by reset.
   always_ff @(negedge Clock) begin
      if (wr_en_s) begin
         mem_r[wr_idx_s] <= wr_data_s;
      end
   end

   assign Req_Ack    = ack_r;
   assign Pull_Valid = valid_r;
   assign Pull_Data  = pull_data_r;
   assign SP_Out     = sp_r;
   assign Full       = full_s;
   assign Empty      = empty_s;
   assign Stack_Err  = err_r;

endmodule

// File: tb/tb_stack_mem_responder.sv
// Self-checking bench for stack_mem_responder: directed vector table, corner sequences and
// randomized push/pull/swap traffic against a queue-based stack model.
module tb_stack_mem_responder;

   logic        Clock = 1'b1;
   logic        Resetn = 1'b0;
   logic        Push_Req = 1'b0;
   logic        Pull_Req = 1'b0;
   logic [31:0] Push_Data = 32'h0;
   logic        Req_Ack;
   logic [31:0] Pull_Data;
   logic        Pull_Valid;
   logic [31:0] SP_Out;
   logic        Full;
   logic        Empty;
   logic        Stack_Err;

   int checks = 0;
   int errors = 0;
   logic [31:0] model_q[$];

   localparam int OP_PUSH = 0;
   localparam int OP_PULL = 1;
   localparam int OP_SWAP = 2;

   typedef struct {
      int          op;
      logic [31:0] data;
      logic [31:0] exp_pd;
      logic [31:0] exp_sp;
      logic        exp_full;
      logic        exp_empty;
   } vec_t;

   vec_t vecs[7];

   stack_mem_responder #(.DEPTH(16), .DW(32), .INIT_SP(32'h54)) dut (
      .Clock(Clock), .Resetn(Resetn), .Push_Req(Push_Req), .Pull_Req(Pull_Req),
      .Push_Data(Push_Data), .Req_Ack(Req_Ack), .Pull_Data(Pull_Data),
      .Pull_Valid(Pull_Valid), .SP_Out(SP_Out), .Full(Full), .Empty(Empty),
      .Stack_Err(Stack_Err)
   );

   always #5 Clock = ~Clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Drive one request, wait (bounded) for the ack, then drop the request; returns at IDLE.
   task automatic do_op(input int op, input logic [31:0] data,
                        output logic [31:0] pd, output logic pv, output int lat);
      Push_Req  = (op == OP_PUSH) || (op == OP_SWAP);
      Pull_Req  = (op == OP_PULL) || (op == OP_SWAP);
      Push_Data = data;
      lat = 0; pd = 32'h0; pv = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         @(posedge Clock);
         if (Req_Ack === 1'b1) begin
            lat = i; pd = Pull_Data; pv = Pull_Valid;
            break;
         end
      end
      Push_Req = 1'b0;
      Pull_Req = 1'b0;
      if (lat == 0) begin
         checks++; errors++;
         $display("FAIL ack_timeout: no Req_Ack within 8 cycles for op %0d", op);
      end
      @(posedge Clock);
   endtask

   task automatic model_apply(input int op, input logic [31:0] data, output logic [31:0] exp_pd);
      exp_pd = 32'h0;
      if (op == OP_PUSH) begin
         model_q.push_back(data);
      end else if (op == OP_PULL) begin
         exp_pd = model_q.pop_back();
      end else begin
         exp_pd = model_q[$];
         model_q[$] = data;
      end
   endtask

   task automatic do_reset(input int cycles);
      Resetn = 1'b0;
      repeat (cycles) @(posedge Clock);
      check("rst_sp", SP_Out, 32'h0);
      check("rst_ack", {31'h0, Req_Ack}, 32'h0);
      check("rst_valid", {31'h0, Pull_Valid}, 32'h0);
      check("rst_pull_data", Pull_Data, 32'h0);
      check("rst_empty", {31'h0, Empty}, 32'h1);
      check("rst_full", {31'h0, Full}, 32'h0);
      check("rst_err", {31'h0, Stack_Err}, 32'h0);
      Resetn = 1'b1;
      @(posedge Clock);
      check("init_sp", SP_Out, 32'h54);
      model_q.delete();
   endtask

   initial begin
      logic [31:0] pd, exp_pd;
      logic        pv;
      int          lat, op;

      vecs[0] = '{OP_PUSH, 32'hA5A5_0001, 32'h0,         32'h56 - 32'h1, 1'b0, 1'b0};
      vecs[1] = '{OP_PUSH, 32'h0000_0040, 32'h0,         32'h56, 1'b0, 1'b0};
      vecs[2] = '{OP_PULL, 32'h0,         32'h0000_0040, 32'h55, 1'b0, 1'b0};
      vecs[3] = '{OP_PULL, 32'h0,         32'hA5A5_0001, 32'h54, 1'b0, 1'b1};
      vecs[4] = '{OP_PUSH, 32'h0000_0011, 32'h0,         32'h55, 1'b0, 1'b0};
      vecs[5] = '{OP_SWAP, 32'h0000_0022, 32'h0000_0011, 32'h55, 1'b0, 1'b0};
      vecs[6] = '{OP_PULL, 32'h0,         32'h0000_0022, 32'h54, 1'b0, 1'b1};

      do_reset(2);

      for (int v = 0; v < 7; v++) begin
         do_op(vecs[v].op, vecs[v].data, pd, pv, lat);
         model_apply(vecs[v].op, vecs[v].data, exp_pd);
         check($sformatf("vec%0d_latency", v), lat, (vecs[v].op == OP_PUSH) ? 32'd1 : 32'd2);
         check($sformatf("vec%0d_valid", v), {31'h0, pv}, (vecs[v].op == OP_PUSH) ? 32'h0 : 32'h1);
         if (vecs[v].op != OP_PUSH) check($sformatf("vec%0d_pull_data", v), pd, vecs[v].exp_pd);
         check($sformatf("vec%0d_sp", v), SP_Out, vecs[v].exp_sp);
         check($sformatf("vec%0d_full", v), {31'h0, Full}, {31'h0, vecs[v].exp_full});
         check($sformatf("vec%0d_empty", v), {31'h0, Empty}, {31'h0, vecs[v].exp_empty});
         check($sformatf("vec%0d_ack_pulse", v), {31'h0, Req_Ack}, 32'h0);
      end

      // Random legal traffic: never push on full or pull/swap on empty.
      for (int n = 0; n < 80; n++) begin
         if (model_q.size() == 0) op = OP_PUSH;
         else if (model_q.size() == 16) op = $urandom_range(2, 1);
         else op = $urandom_range(2, 0);
         pd = $urandom;
         do_op(op, pd, pd, pv, lat);
         model_apply(op, Push_Data, exp_pd);
         check("rand_latency", lat, (op == OP_PUSH) ? 32'd1 : 32'd2);
         check("rand_valid", {31'h0, pv}, (op == OP_PUSH) ? 32'h0 : 32'h1);
         if (op != OP_PUSH) check("rand_pull_data", pd, exp_pd);
         check("rand_sp", SP_Out, 32'h54 + model_q.size());
         check("rand_full", {31'h0, Full}, (model_q.size() == 16) ? 32'h1 : 32'h0);
         check("rand_empty", {31'h0, Empty}, (model_q.size() == 0) ? 32'h1 : 32'h0);
         check("rand_err", {31'h0, Stack_Err}, 32'h0);
      end

      // Reset asserted while a pull is in READ: no ack, SP back to 0 then INIT_SP.
      do_op(OP_PUSH, 32'h1234_5678, pd, pv, lat);
      Pull_Req = 1'b1;
      @(posedge Clock);
      Resetn = 1'b0;
      @(posedge Clock);
      check("rst_read_ack", {31'h0, Req_Ack}, 32'h0);
      check("rst_read_valid", {31'h0, Pull_Valid}, 32'h0);
      check("rst_read_sp", SP_Out, 32'h0);
      Pull_Req = 1'b0;
      Resetn = 1'b1;
      @(posedge Clock);
      check("rst_read_init_sp", SP_Out, 32'h54);
      check("rst_read_empty", {31'h0, Empty}, 32'h1);
      @(posedge Clock);
      check("rst_read_no_late_ack", {31'h0, Req_Ack}, 32'h0);

      // Fill to full, then one more push.
      for (int i = 0; i < 16; i++) do_op(OP_PUSH, 32'hC000_0000 + i, pd, pv, lat);
      check("fill_full", {31'h0, Full}, 32'h1);
      check("fill_sp", SP_Out, 32'h64);
      do_op(OP_PUSH, 32'hDEAD_0017, pd, pv, lat);
      check("ovf_latency", lat, 32'd1);
`ifdef STACK_GUARD_EN
      check("ovf_sp", SP_Out, 32'h64);
      check("ovf_err", {31'h0, Stack_Err}, 32'h1);
      check("ovf_full", {31'h0, Full}, 32'h1);
`else
      check("ovf_sp", SP_Out, 32'h65);
      check("ovf_full", {31'h0, Full}, 32'h0);
      check("ovf_err", {31'h0, Stack_Err}, 32'h0);
      do_op(OP_PULL, 32'h0, pd, pv, lat);
      check("ovf_pull_data", pd, 32'hDEAD_0017);
      check("ovf_pull_sp", SP_Out, 32'h64);
`endif

      do_reset(2);

`ifdef STACK_GUARD_EN
      do_op(OP_PULL, 32'h0, pd, pv, lat);
      check("udf_valid", {31'h0, pv}, 32'h1);
      check("udf_pull_data", pd, 32'h0);
      check("udf_sp", SP_Out, 32'h54);
      check("udf_err", {31'h0, Stack_Err}, 32'h1);
      check("udf_empty", {31'h0, Empty}, 32'h1);
`else
      do_op(OP_PUSH, 32'h0000_0099, pd, pv, lat);
      do_op(OP_PULL, 32'h0, pd, pv, lat);
      check("post_rst_pull_data", pd, 32'h0000_0099);
      check("post_rst_sp", SP_Out, 32'h54);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
